// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - IF/ID and ID/EX stall, bubble and flush sequencing
// Load-use stalls and EX redirects, plus saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             jump_EX,
  input  logic             mispredict_EX,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             redirect_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {S_RUN, S_LD_STALL, S_REDIRECT} state_t;

  localparam logic [2:0] LOAD_RELOAD  = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYC - 1);

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_redir;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_lu_hz;
  logic w_stall;
  logic w_flush;
  logic w_busy;

  assign w_redir   = jump_EX | mispredict_EX;
  assign w_rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
  assign w_lu_hz   = id_valid && ex_valid && ex_is_load && (ex_rd != 5'd0)
                     && (w_rs1_hit || w_rs2_hit);

  // Response is combinational so the pipe registers react in the same cycle;
  // reset forces everything low while it is held.
  always_comb begin
    w_stall = 1'b0;
    w_flush = 1'b0;
    w_busy  = 1'b0;
    if (reset) begin
      case (r_state)
        S_RUN: begin
          if (w_redir)      w_flush = 1'b1;
          else if (w_lu_hz) w_stall = 1'b1;
        end
        S_LD_STALL: begin
          if (w_redir) w_flush = 1'b1;
          else         w_stall = 1'b1;
        end
        S_REDIRECT: begin
          w_flush = 1'b1;
          w_busy  = 1'b1;
        end
        default: begin
          w_stall = 1'b0;
        end
      endcase
    end
  end

  assign pc_stall      = w_stall;
  assign if_id_stall   = w_stall;
  assign if_id_flush   = w_flush;
  assign id_ex_bubble  = w_stall | w_flush;
  assign redirect_busy = w_busy;
  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_redir) begin
            if (FLUSH_CYC > 1) begin
              r_state <= S_REDIRECT;
              r_cnt   <= FLUSH_RELOAD;
            end
          end else if (w_lu_hz && (LOAD_LAT > 1)) begin
            r_state <= S_LD_STALL;
            r_cnt   <= LOAD_RELOAD;
          end
        end
        S_LD_STALL: begin
          if (w_redir) begin
            r_state <= (FLUSH_CYC > 1) ? S_REDIRECT : S_RUN;
            r_cnt   <= FLUSH_RELOAD;
          end else begin
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt <= 3'd1) r_state <= S_RUN;
          end
        end
        S_REDIRECT: begin
          // A fresh redirect restarts the whole flush window.
          if (w_redir) begin
            r_cnt <= FLUSH_RELOAD;
          end else begin
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt <= 3'd1) r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_redir && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
// Instance a: defaults; instance b: LOAD_LAT=3, FLUSH_CYC=2, CNT_W=4.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs1, id_use_rs2, ex_valid, ex_is_load, jump_EX, mispredict_EX;
  logic [4:0] id_rs1, id_rs2, ex_rd;

  logic        a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_bubble, a_redirect_busy;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_bubble, b_redirect_busy;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_dut_a (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .jump_EX(jump_EX), .mispredict_EX(mispredict_EX),
    .pc_stall(a_pc_stall), .if_id_stall(a_if_id_stall), .if_id_flush(a_if_id_flush),
    .id_ex_bubble(a_id_ex_bubble), .redirect_busy(a_redirect_busy),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipeline_hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYC(2), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .jump_EX(jump_EX), .mispredict_EX(mispredict_EX),
    .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall), .if_id_flush(b_if_id_flush),
    .id_ex_bubble(b_id_ex_bubble), .redirect_busy(b_redirect_busy),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  // Output vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, redirect_busy}
  wire [4:0] a_outs = {a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_bubble, a_redirect_busy};
  wire [4:0] b_outs = {b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_bubble, b_redirect_busy};

  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_STALL = 5'b11010;
  localparam logic [4:0] O_FLUSH = 5'b00110;
  localparam logic [4:0] O_BUSY  = 5'b00111;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd = 0; jump_EX = 0; mispredict_EX = 0;
  endtask

  // Load in EX writing rd, ID reading rs1 (u1) and rs2 (u2).
  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    clr_in();
    id_valid = 1; ex_valid = 1; ex_is_load = 1; ex_rd = rd;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
  endtask

  // Advance to the next negedge; inputs applied there, outputs sampled 1 ns later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(); reset = 0; clr_in();
    cyc(); reset = 1;
  endtask

  initial begin
    clr_in();
    reset = 0;
    // Reset holds outputs low even with a redirect and hazard on the inputs.
    cyc(); set_lu(5'd5, 5'd5, 1, 5'd0, 0); jump_EX = 1; #1;
    check("rst_outs_a", a_outs, O_IDLE);
    check("rst_outs_b", b_outs, O_IDLE);
    check("rst_cnts_a", {a_stall_cnt, a_flush_cnt}, 32'd0);
    cyc(); clr_in(); reset = 1;

    // Test 1: single-cycle load-use stall.
    cyc(); set_lu(5'd5, 5'd5, 1, 5'd0, 0); #1;
    check("t1_stall", a_outs, O_STALL);
    cyc(); clr_in(); #1;
    check("t1_after", a_outs, O_IDLE);
    check("t1_stall_cnt", a_stall_cnt, 32'd1);

    // Test 2: no hazard cases.
    set_lu(5'd0, 5'd0, 1, 5'd0, 1); #1;
    check("t2_rd0", a_outs, O_IDLE);
    cyc(); set_lu(5'd5, 5'd5, 0, 5'd9, 1); #1;
    check("t2_nouse", a_outs, O_IDLE);
    cyc(); set_lu(5'd7, 5'd1, 1, 5'd7, 1); ex_valid = 0; #1;
    check("t2_exinv", a_outs, O_IDLE);
    cyc(); set_lu(5'd7, 5'd1, 1, 5'd7, 1); #1;
    check("t2_rs2_hit", a_outs, O_STALL);
    cyc(); clr_in(); #1;
    check("t2_stall_cnt", a_stall_cnt, 32'd2);

    // Test 3: one-cycle jump pulse, two-cycle flush window.
    do_reset();
    jump_EX = 1; #1;
    check("t3_T", a_outs, O_FLUSH);
    cyc(); clr_in(); #1;
    check("t3_T1", a_outs, O_BUSY);
    check("t3_flush_cnt", a_flush_cnt, 32'd1);
    cyc(); #1;
    check("t3_T2", a_outs, O_IDLE);

    // Test 4: mispredict beats simultaneous load-use.
    set_lu(5'd3, 5'd3, 1, 5'd0, 0); mispredict_EX = 1; #1;
    check("t4_prio", a_outs, O_FLUSH);
    cyc(); clr_in(); #1;
    check("t4_busy", a_outs, O_BUSY);
    check("t4_stall_cnt", a_stall_cnt, 32'd0);
    check("t4_flush_cnt", a_flush_cnt, 32'd2);
    cyc(); #1;
    check("t4_idle", a_outs, O_IDLE);

    // Redirect during REDIRECT restarts the window.
    do_reset();
    jump_EX = 1; #1;
    check("rr_T", a_outs, O_FLUSH);
    cyc(); #1;
    check("rr_T1", a_outs, O_BUSY);
    cyc(); clr_in(); #1;
    check("rr_T2", a_outs, O_BUSY);
    cyc(); #1;
    check("rr_T3", a_outs, O_IDLE);
    check("rr_flush_cnt", a_flush_cnt, 32'd2);

    // Test 5: LOAD_LAT=3 full stall, then a redirect in the 2nd stall cycle.
    do_reset();
    set_lu(5'd4, 5'd4, 1, 5'd0, 0); #1;
    check("t5_s1", b_outs, O_STALL);
    cyc(); clr_in(); #1;
    check("t5_s2", b_outs, O_STALL);
    cyc(); #1;
    check("t5_s3", b_outs, O_STALL);
    cyc(); #1;
    check("t5_done", b_outs, O_IDLE);
    check("t5_stall_cnt3", b_stall_cnt, 32'd3);
    set_lu(5'd4, 5'd4, 1, 5'd0, 0); #1;
    check("t5_r1", b_outs, O_STALL);
    cyc(); clr_in(); jump_EX = 1; #1;
    check("t5_r2", b_outs, O_FLUSH);
    cyc(); clr_in(); #1;
    check("t5_r3", b_outs, O_BUSY);
    check("t5_stall_cnt", b_stall_cnt, 32'd4);
    cyc(); #1;
    check("t5_r4", b_outs, O_IDLE);
    check("t5_flush_cnt", b_flush_cnt, 32'd1);

    // Test 6: saturation at 4 bits, then reset in the middle of a redirect.
    do_reset();
    set_lu(5'd8, 5'd0, 0, 5'd8, 1);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (b_outs !== O_STALL) check($sformatf("t6_stall_%0d", i), b_outs, O_STALL);
      cyc();
    end
    #1;
    check("t6_sat", b_stall_cnt, 32'd15);
    jump_EX = 1; #1;
    check("t6_flush", b_outs, O_FLUSH);
    cyc(); clr_in(); #1;
    check("t6_busy", b_outs, O_BUSY);
    reset = 0; #1;
    check("t6_rst_outs", b_outs, O_IDLE);
    check("t6_rst_cnts", {b_stall_cnt, b_flush_cnt}, 32'd0);
    check("t6_rst_a", {a_stall_cnt, a_flush_cnt}, 32'd0);
    cyc(); reset = 1;
    cyc(); #1;
    check("t6_post", b_outs, O_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
